spi_scene_decoder: RTL and testbench

- Consumes 64-bit words from the SPI slave (recv_dv / recv_64bit) and decodes them as scene-load packets.
- Writes sphere records into a double-buffered scene memory owned by the raytracing controller, and latches camera words.
- Swaps buffers only at a frame boundary reported by the controller.
- Drives the host flow-control line (recv_interrupt). Sits between SPI_Slave_64 and Raytracing_Controller in the CLK100MHZ domain.

---
 rtl/spi_scene_decoder_if.sv | 33 +++
 rtl/spi_scene_decoder.sv | 174 +++++++++++++++++
 tb/tb_spi_scene_decoder.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_scene_decoder_if.sv
// Signal bundle between the SPI receive path, the scene decoder and the raytracing controller.
// slave = decoder side, master = host/controller side.
interface spi_scene_decoder_if #(
    parameter int MAX_SPHERES = 8
);
    localparam int AW = $clog2(MAX_SPHERES);

    logic          recv_dv;
    logic [63:0]   recv_64bit;
    logic          sph_we;
    logic          sph_bank;
    logic [AW-1:0] sph_addr;
    logic [63:0]   sph_data;
    logic          cam_valid;
    logic [63:0]   cam_data;
    logic [AW:0]   sph_count;
    logic          front_bank;
    logic          frame_done;
    logic          recv_interrupt;
    logic [7:0]    err_cnt;

    modport slave (
        input  recv_dv, recv_64bit, frame_done,
        output sph_we, sph_bank, sph_addr, sph_data, cam_valid, cam_data,
               sph_count, front_bank, recv_interrupt, err_cnt
    );

    modport master (
        output recv_dv, recv_64bit, frame_done,
        input  sph_we, sph_bank, sph_addr, sph_data, cam_valid, cam_data,
               sph_count, front_bank, recv_interrupt, err_cnt
    );
endinterface

// File: rtl/spi_scene_decoder.sv
// Decodes SPI scene-load packets into double-buffered sphere writes, camera words and bank swaps.
// Optional SCENE_CHECKSUM_EN: COMMIT aux must match the XOR of sphere-word low halves.
module spi_scene_decoder #(
    parameter int MAX_SPHERES = 8,
    localparam int AW = $clog2(MAX_SPHERES)
) (
    input logic               CLK100MHZ,
    input logic               ck_rst_,
    spi_scene_decoder_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_SPH, S_CAM, S_PEND} state_t;

    localparam logic [7:0] OP_LOAD   = 8'h01;
    localparam logic [7:0] OP_CAM    = 8'h02;
    localparam logic [7:0] OP_COMMIT = 8'h03;

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [AW:0]   back_cnt_q, back_cnt_d;
    logic [AW:0]   sph_count_q, sph_count_d;
    logic          front_q, front_d;
    logic          sph_we_q, sph_we_d;
    logic [AW-1:0] sph_addr_q, sph_addr_d;
    logic [63:0]   sph_data_q, sph_data_d;
    logic          cam_valid_q, cam_valid_d;
    logic [63:0]   cam_data_q, cam_data_d;
    logic [7:0]    err_cnt_q, err_cnt_d;
    logic          recv_int_q, recv_int_d;
    logic          err_inc;

    logic [7:0] op, n;
    logic       n_ok, last_word, commit_ok;

    assign op        = bus.recv_64bit[63:56];
    assign n         = bus.recv_64bit[55:48];
    assign n_ok      = (n != 8'd0) && (int'(n) <= MAX_SPHERES);
    assign last_word = ({1'b0, idx_q} + (AW+1)'(1)) == back_cnt_q;

`ifdef SCENE_CHECKSUM_EN
    logic [15:0] csum_q, csum_d;
    assign commit_ok = (bus.recv_64bit[15:0] == csum_q);
`else
    assign commit_ok = 1'b1;
`endif

    // State register and all registered outputs
    always_ff @(posedge CLK100MHZ or negedge ck_rst_) begin
        if (!ck_rst_) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            back_cnt_q  <= '0;
            sph_count_q <= '0;
            front_q     <= 1'b0;
            sph_we_q    <= 1'b0;
            sph_addr_q  <= '0;
            sph_data_q  <= '0;
            cam_valid_q <= 1'b0;
            cam_data_q  <= '0;
            err_cnt_q   <= '0;
            recv_int_q  <= 1'b1;
`ifdef SCENE_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            back_cnt_q  <= back_cnt_d;
            sph_count_q <= sph_count_d;
            front_q     <= front_d;
            sph_we_q    <= sph_we_d;
            sph_addr_q  <= sph_addr_d;
            sph_data_q  <= sph_data_d;
            cam_valid_q <= cam_valid_d;
            cam_data_q  <= cam_data_d;
            err_cnt_q   <= err_cnt_d;
            recv_int_q  <= recv_int_d;
`ifdef SCENE_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (bus.recv_dv) begin
                case (op)
                    OP_LOAD:   if (n_ok) state_d = S_SPH;
                    OP_CAM:    state_d = S_CAM;
                    OP_COMMIT: if (commit_ok) state_d = S_PEND;
                    default:   state_d = S_IDLE;
                endcase
            end
            S_SPH:  if (bus.recv_dv && last_word) state_d = S_IDLE;
            S_CAM:  if (bus.recv_dv) state_d = S_IDLE;
            S_PEND: if (bus.frame_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        idx_d       = idx_q;
        back_cnt_d  = back_cnt_q;
        sph_count_d = sph_count_q;
        front_d     = front_q;
        sph_we_d    = 1'b0;
        sph_addr_d  = sph_addr_q;
        sph_data_d  = sph_data_q;
        cam_valid_d = 1'b0;
        cam_data_d  = cam_data_q;
        err_inc     = 1'b0;
`ifdef SCENE_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        unique case (state_q)
            S_IDLE: if (bus.recv_dv) begin
                case (op)
                    OP_LOAD: begin
                        if (n_ok) begin
                            idx_d      = '0;
                            back_cnt_d = n[AW:0];
                        end else if (n != 8'd0) begin
                            err_inc = 1'b1;
                        end
                    end
                    OP_CAM: ;
                    OP_COMMIT: begin
`ifdef SCENE_CHECKSUM_EN
                        // Accepted or not, the running XOR restarts at every COMMIT
                        csum_d  = '0;
                        err_inc = !commit_ok;
`endif
                    end
                    default: err_inc = 1'b1;
                endcase
            end
            S_SPH: if (bus.recv_dv) begin
                sph_we_d   = 1'b1;
                sph_addr_d = idx_q;
                sph_data_d = bus.recv_64bit;
                idx_d      = idx_q + AW'(1);
`ifdef SCENE_CHECKSUM_EN
                csum_d     = csum_q ^ bus.recv_64bit[15:0];
`endif
            end
            S_CAM: if (bus.recv_dv) begin
                cam_valid_d = 1'b1;
                cam_data_d  = bus.recv_64bit;
            end
            S_PEND: begin
                // A word arriving while the swap is pending is lost, even alongside frame_done
                err_inc = bus.recv_dv;
                if (bus.frame_done) begin
                    front_d     = ~front_q;
                    sph_count_d = back_cnt_q;
                end
            end
            default: ;
        endcase
        err_cnt_d  = (err_inc && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
        recv_int_d = (state_d != S_PEND);
    end

    assign bus.sph_we         = sph_we_q;
    assign bus.sph_bank       = ~front_q;
    assign bus.sph_addr       = sph_addr_q;
    assign bus.sph_data       = sph_data_q;
    assign bus.cam_valid      = cam_valid_q;
    assign bus.cam_data       = cam_data_q;
    assign bus.sph_count      = sph_count_q;
    assign bus.front_bank     = front_q;
    assign bus.recv_interrupt = recv_int_q;
    assign bus.err_cnt        = err_cnt_q;
endmodule

// File: tb/tb_spi_scene_decoder.sv
// Scoreboard bench for spi_scene_decoder: a packet-level model queues expected writes,
// a monitor compares them as the DUT emits them; status outputs are checked every cycle.
module tb_spi_scene_decoder;
    localparam int MAX = 8;
    localparam int AW  = $clog2(MAX);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_scene_decoder_if #(.MAX_SPHERES(MAX)) bus ();

    spi_scene_decoder #(.MAX_SPHERES(MAX)) dut (
        .CLK100MHZ (clk),
        .ck_rst_   (rst_n),
        .bus       (bus)
    );

    int total = 0;
    int bad   = 0;

    // expected sphere writes {bank, addr, data} and camera words
    logic [AW+64:0] sph_q[$];
    logic [63:0]    cam_q[$];

    // reference model: mode 0 idle, 1 loading spheres, 2 awaiting camera, 3 swap pending
    int          m_mode  = 0;
    int          m_left  = 0;
    int          m_idx   = 0;
    int          m_back  = 0;
    int          m_count = 0;
    int          m_err   = 0;
    logic        m_front = 1'b0;
    logic [15:0] m_csum  = 16'h0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] hdr(input logic [7:0] op, input logic [7:0] n, input logic [15:0] aux);
        return {op, n, 32'h0, aux};
    endfunction

    task automatic bump_err();
        if (m_err < 255) m_err++;
    endtask

    task automatic model(input logic dv, input logic [63:0] w, input logic fd);
        int op, n;
        op = int'(w[63:56]);
        n  = int'(w[55:48]);
        if (m_mode == 3) begin
            if (dv) bump_err();
            if (fd) begin
                m_front = ~m_front;
                m_count = m_back;
                m_mode  = 0;
            end
        end else if (dv) begin
            case (m_mode)
                0: begin
                    if (op == 1) begin
                        if (n > MAX) bump_err();
                        else if (n > 0) begin
                            m_mode = 1; m_left = n; m_idx = 0; m_back = n;
                        end
                    end else if (op == 2) m_mode = 2;
                    else if (op == 3) begin
`ifdef SCENE_CHECKSUM_EN
                        if (w[15:0] == m_csum) m_mode = 3;
                        else bump_err();
                        m_csum = 16'h0;
`else
                        m_mode = 3;
`endif
                    end else bump_err();
                end
                1: begin
                    sph_q.push_back({~m_front, AW'(m_idx), w});
                    m_csum = m_csum ^ w[15:0];
                    m_idx++;
                    m_left--;
                    if (m_left == 0) m_mode = 0;
                end
                default: begin
                    cam_q.push_back(w);
                    m_mode = 0;
                end
            endcase
        end
    endtask

    // one clock of stimulus; status outputs are compared just after the edge
    task automatic drive(input logic dv, input logic [63:0] w, input logic fd);
        bus.recv_dv    = dv;
        bus.recv_64bit = w;
        bus.frame_done = fd;
        model(dv, w, fd);
        @(posedge clk);
        #1;
        chk("err_cnt", 64'(bus.err_cnt), 64'(m_err));
        chk("front_bank", 64'(bus.front_bank), 64'(m_front));
        chk("sph_count", 64'(bus.sph_count), 64'(m_count));
        chk("recv_interrupt", 64'(bus.recv_interrupt), 64'(m_mode != 3));
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) drive(1'b0, 64'h0, 1'b0);
    endtask

    task automatic rdrive(input logic dv, input logic [63:0] w);
        drive(dv, w, $urandom_range(0, 5) == 0);
    endtask

    task automatic rword(input logic [63:0] w);
        int gap;
        gap = $urandom_range(0, 2);
        for (int i = 0; i < gap; i++) rdrive(1'b0, 64'h0);
        rdrive(1'b1, w);
    endtask

    task automatic mon();
        logic [AW+64:0] e;
        logic [63:0]    c;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.sph_we) begin
                    if (sph_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL sph_we: got write addr %0d want none", bus.sph_addr);
                    end else begin
                        e = sph_q.pop_front();
                        chk("sph_bank", 64'(bus.sph_bank), 64'(e[AW+64]));
                        chk("sph_addr", 64'(bus.sph_addr), 64'(e[AW+63:64]));
                        chk("sph_data", bus.sph_data, e[63:0]);
                    end
                end
                if (bus.cam_valid) begin
                    if (cam_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL cam_valid: got pulse data %h want none", bus.cam_data);
                    end else begin
                        c = cam_q.pop_front();
                        chk("cam_data", bus.cam_data, c);
                    end
                end
            end
        end
    endtask

    initial begin
        logic [63:0] a, b, cc, w;
        int kind, n;
        bus.recv_dv    = 1'b0;
        bus.recv_64bit = 64'h0;
        bus.frame_done = 1'b0;
        fork mon(); join_none

        repeat (3) @(posedge clk);
        #1;
        chk("rst_sph_we", 64'(bus.sph_we), 64'h0);
        chk("rst_cam_valid", 64'(bus.cam_valid), 64'h0);
        chk("rst_cam_data", bus.cam_data, 64'h0);
        chk("rst_sph_addr", 64'(bus.sph_addr), 64'h0);
        chk("rst_sph_data", bus.sph_data, 64'h0);
        chk("rst_err_cnt", 64'(bus.err_cnt), 64'h0);
        chk("rst_recv_interrupt", 64'(bus.recv_interrupt), 64'h1);
        chk("rst_front_bank", 64'(bus.front_bank), 64'h0);
        chk("rst_sph_count", 64'(bus.sph_count), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // three back-to-back sphere words
        a  = 64'hAAAA_0000_1111_00F0;
        b  = 64'hBBBB_0000_2222_0F0F;
        cc = 64'hCCCC_0000_3333_1234;
        drive(1'b1, hdr(8'h01, 8'd3, 16'h0), 1'b0);
        chk("t1_no_we_on_header", 64'(bus.sph_we), 64'h0);
        drive(1'b1, a, 1'b0);
        chk("t1_we_after_A", 64'(bus.sph_we), 64'h1);
        chk("t1_bank", 64'(bus.sph_bank), 64'h1);
        drive(1'b1, b, 1'b0);
        drive(1'b1, cc, 1'b0);
        chk("t1_addr_C", 64'(bus.sph_addr), 64'h2);
        idle(2);

        // camera word
        drive(1'b1, hdr(8'h02, 8'd0, 16'h0), 1'b0);
        drive(1'b1, 64'h1234, 1'b0);
        chk("t2_cam_valid", 64'(bus.cam_valid), 64'h1);
        chk("t2_cam_data", bus.cam_data, 64'h1234);
        idle(1);
        chk("t2_cam_valid_drop", 64'(bus.cam_valid), 64'h0);

        // commit, swap after 10 idle cycles
        drive(1'b1, hdr(8'h03, 8'd0, 16'h00F0 ^ 16'h0F0F ^ 16'h1234), 1'b0);
        idle(10);
        chk("t3_int_low", 64'(bus.recv_interrupt), 64'h0);
        drive(1'b0, 64'h0, 1'b1);
        chk("t3_front", 64'(bus.front_bank), 64'h1);
        chk("t3_count", 64'(bus.sph_count), 64'h3);
        chk("t3_int_high", 64'(bus.recv_interrupt), 64'h1);

        // words dropped while pending, the second with frame_done
        drive(1'b1, hdr(8'h03, 8'd0, 16'h0), 1'b0);
        drive(1'b1, 64'hDEAD_BEEF_0000_0001, 1'b0);
        drive(1'b0, 64'h0, 1'b0);
        drive(1'b1, 64'hDEAD_BEEF_0000_0002, 1'b1);
        chk("t4_err", 64'(bus.err_cnt), 64'd2);
        chk("t4_front", 64'(bus.front_bank), 64'h0);

        // bad opcode, oversize load, empty load
        drive(1'b1, hdr(8'h7F, 8'd0, 16'h0), 1'b0);
        drive(1'b1, hdr(8'h01, 8'd9, 16'h0), 1'b0);
        drive(1'b1, hdr(8'h01, 8'd0, 16'h0), 1'b0);
        idle(2);
        chk("t5_err", 64'(bus.err_cnt), 64'd4);
        chk("t5_int", 64'(bus.recv_interrupt), 64'h1);

`ifdef SCENE_CHECKSUM_EN
        drive(1'b1, hdr(8'h01, 8'd2, 16'h0), 1'b0);
        drive(1'b1, 64'h1111_0000_0000_00F0, 1'b0);
        drive(1'b1, 64'h2222_0000_0000_0F0F, 1'b0);
        drive(1'b1, hdr(8'h03, 8'd0, 16'h0FFF), 1'b0);
        idle(2);
        drive(1'b0, 64'h0, 1'b1);
        chk("t6_front_swap", 64'(bus.front_bank), 64'h1);
        chk("t6_count", 64'(bus.sph_count), 64'h2);
        drive(1'b1, hdr(8'h01, 8'd2, 16'h0), 1'b0);
        drive(1'b1, 64'h1111_0000_0000_00F0, 1'b0);
        drive(1'b1, 64'h2222_0000_0000_0F0F, 1'b0);
        drive(1'b1, hdr(8'h03, 8'd0, 16'h0000), 1'b0);
        chk("t6_bad_err", 64'(bus.err_cnt), 64'd5);
        chk("t6_bad_int", 64'(bus.recv_interrupt), 64'h1);
        drive(1'b0, 64'h0, 1'b1);
        chk("t6_no_swap", 64'(bus.front_bank), 64'h1);
`endif

        // randomized packet stream with random gaps and frame_done
        for (int p = 0; p < 300; p++) begin
            kind = $urandom_range(0, 9);
            w    = {$urandom, $urandom};
            if (kind <= 3) begin
                n = $urandom_range(0, 10);
                rword(hdr(8'h01, 8'(n), w[15:0]));
                for (int i = 0; i < ((n > MAX) ? 2 : n); i++) rword({$urandom, $urandom});
            end else if (kind <= 5) begin
                rword(hdr(8'h02, 8'h0, 16'h0));
                rword(w);
            end else if (kind <= 7) begin
                rword(hdr(8'h03, 8'h0, ($urandom_range(0, 3) != 0) ? m_csum : w[15:0]));
            end else if (kind == 8) begin
                rword(hdr(8'($urandom_range(4, 255)), 8'h0, 16'h0));
            end else begin
                rword(w);
            end
        end
        idle(2);
        drive(1'b0, 64'h0, 1'b1);
        idle(2);

        // error counter saturation
        for (int i = 0; i < 260; i++) drive(1'b1, hdr(8'hEE, 8'h0, 16'h0), 1'b0);
        chk("err_saturated", 64'(bus.err_cnt), 64'd255);
        idle(3);
        chk("sph_q_drained", 64'(sph_q.size()), 64'h0);
        chk("cam_q_drained", 64'(cam_q.size()), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
